reg_bank_arbiter: RTL
=====================

// Module: reg_bank_arbiter
// PURPOSE
//  Shares one bank of NrOfRegs tri-state registers (single-bit-wide ClockEnable, active-high cs =
//  output high-Z) between two requesters: port 0 = CPU datapath, port 1 = debug/loader.
//  Round-robin arbitration; sequences each access as grant -> register strobe -> response.
//  Drives the per-register ClockEnable/cs lines and D bus; samples the shared Q bus on reads.
// PARAMETERS
//  NrOfBits  32  register / data width
//  NrOfRegs  8   registers in the bank (2..32)
//  AddrBits  3   address width; must satisfy 2**AddrBits >= NrOfRegs
// PORTS
//  Clock     in   1            system clock, all state on rising edge
//  Reset     in   1            synchronous, active-high reset
//  req0      in   1            port 0 request; held high until gnt0
//  we0       in   1            port 0: 1 = write, 0 = read
//  addr0     in   AddrBits     port 0 register index
//  wdata0    in   NrOfBits     port 0 write data
//  req1/we1/addr1/wdata1       port 1, same meaning as port 0
//  gnt0      out  1            1-cycle pulse: port 0 request accepted
//  gnt1      out  1            1-cycle pulse: port 1 request accepted
//  done0     out  1            1-cycle pulse: port 0 access complete
//  done1     out  1            1-cycle pulse: port 1 access complete
//  rdata     out  NrOfBits     read result, valid while done0|done1 for a read
//  reg_en    out  NrOfRegs     per-register ClockEnable, at most one bit high
//  reg_cs    out  NrOfRegs     per-register cs (1 = Q high-Z), at most one bit low
//  reg_d     out  NrOfBits     shared D bus to all registers
//  bus_q     in   NrOfBits     resolved shared Q bus from the bank
// BEHAVIOUR
//  States: IDLE -> GRANT -> ACCESS -> RESP -> IDLE. Single transaction in flight.
//  IDLE: if any req, choose winner, latch its we/addr/wdata and id, go GRANT. Else stay.
//  Arbitration: one requester -> it wins. Both -> the port NOT granted last wins. last_grant resets
//   to 1, so port 0 wins the first tie. last_grant updates on every grant.
//  GRANT: gnt<id>=1 for this cycle only; requester may drop or change req/addr/wdata from the next
//   cycle (latched copy is used). Go ACCESS.
//  ACCESS (exactly 1 cycle): write -> reg_en[addr]=1, reg_d=latched wdata; read -> reg_cs[addr]=0,
//   bus_q sampled into rdata at the end of this cycle. Go RESP.
//  RESP: done<id>=1 for 1 cycle; rdata holds read value (0 for a write). Go IDLE.
//  Latency: req sampled high in IDLE at edge N -> gnt at cycle N+1, strobe at N+2, done at N+3.
//   Minimum 4 cycles per transaction; back-to-back requests: next grant 4 cycles after previous.
//  Out of range (addr >= NrOfRegs): no reg_en/reg_cs bit asserted; read returns rdata=0; still done.
//  Outside ACCESS: reg_en all 0, reg_cs all 1, reg_d = 0.
//  rdata holds its value until the next RESP.
//  req dropped before grant: no effect if dropped before IDLE samples it; once latched, completes.
//  Reset (any state, incl. mid-access): next state IDLE, in-flight transaction discarded
//   (no done), gnt0/gnt1/done0/done1=0, rdata=0, reg_en=0, reg_cs=all 1, reg_d=0, last_grant=1.
// TESTING
//  1 Reset, port0 write addr=3 data=0xDEADBEEF -> gnt0 @+1, reg_en=8'b0000_1000 & reg_d=0xDEADBEEF
//    @+2 only, done0 @+3.
//  2 Model bank holds 0x12345678 at reg 5; port1 read addr=5 -> reg_cs=8'b1101_1111 @+2,
//    done1 @+3 with rdata=0x12345678.
//  3 req0 and req1 high together from reset, held -> grant order 0,1,0,1 with grants spaced 4 cycles.
//  4 Port0 read addr=7 with NrOfRegs=6 -> no reg_cs bit low, done0 with rdata=0.
//  5 Reset asserted in ACCESS of a write -> reg_en=0 next cycle, no done, next tie grants port 0.
//  6 Checker every cycle: $onehot0(reg_en), $onehot0(~reg_cs), never reg_en and ~reg_cs together.

Source files
------------

// File: rtl/reg_bank_arbiter_if.sv
// Request/response and register-bank signals shared by the two requesters,
// the bank arbiter and the tri-state register bank.
interface reg_bank_arbiter_if #(
  parameter int NrOfBits = 32,
  parameter int NrOfRegs = 8,
  parameter int AddrBits = 3
);
  logic                req0;
  logic                we0;
  logic [AddrBits-1:0] addr0;
  logic [NrOfBits-1:0] wdata0;
  logic                req1;
  logic                we1;
  logic [AddrBits-1:0] addr1;
  logic [NrOfBits-1:0] wdata1;
  logic                gnt0;
  logic                gnt1;
  logic                done0;
  logic                done1;
  logic [NrOfBits-1:0] rdata;
  logic [NrOfRegs-1:0] reg_en;
  logic [NrOfRegs-1:0] reg_cs;
  logic [NrOfBits-1:0] reg_d;
  logic [NrOfBits-1:0] bus_q;

  // Requesters plus the register bank (the bank drives bus_q)
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output bus_q,
    input  gnt0, gnt1, done0, done1, rdata,
    input  reg_en, reg_cs, reg_d
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  bus_q,
    output gnt0, gnt1, done0, done1, rdata,
    output reg_en, reg_cs, reg_d
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one tri-state register bank between a CPU port (0)
// and a debug/loader port (1); each access runs grant -> strobe -> response.
module reg_bank_arbiter #(
  parameter int NrOfBits = 32,
  parameter int NrOfRegs = 8,
  parameter int AddrBits = 3
) (
  input logic               i_clk,
  input logic               i_rst,
  reg_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_id;
  logic                r_we;
  logic [AddrBits-1:0] r_addr;
  logic [NrOfBits-1:0] r_wdata;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_done0;
  logic                r_done1;
  logic [NrOfBits-1:0] r_rdata;
  logic [NrOfRegs-1:0] r_reg_en;
  logic [NrOfRegs-1:0] r_reg_cs;
  logic [NrOfBits-1:0] r_reg_d;

  logic                w_any_req;
  logic                w_pick1;
  logic [NrOfRegs-1:0] w_sel;

  // One-hot register select; an index beyond the bank selects nothing.
  function automatic logic [NrOfRegs-1:0] f_decode(input logic [AddrBits-1:0] addr);
    logic [NrOfRegs-1:0] v;
    v = '0;
    for (int i = 0; i < NrOfRegs; i++) begin
      if (addr == AddrBits'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // Arbitration: on a tie the port not granted last wins
  always_comb begin
    w_any_req = bus.req0 | bus.req1;
    w_pick1   = bus.req1 & (~bus.req0 | ~r_last_grant);
    w_sel     = f_decode(r_addr);
  end

  // Transaction sequencer with registered handshake and bank-strobe outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_rdata      <= '0;
      r_reg_en     <= '0;
      r_reg_cs     <= '1;
      r_reg_d      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_id         <= w_pick1;
            r_last_grant <= w_pick1;
            r_we         <= w_pick1 ? bus.we1    : bus.we0;
            r_addr       <= w_pick1 ? bus.addr1  : bus.addr0;
            r_wdata      <= w_pick1 ? bus.wdata1 : bus.wdata0;
            r_gnt0       <= ~w_pick1;
            r_gnt1       <= w_pick1;
            r_state      <= ST_GRANT;
          end else begin
            r_state      <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
          // Strobes are registered here so they are high for exactly the ACCESS cycle
          if (r_we) begin
            r_reg_en <= w_sel;
            r_reg_d  <= r_wdata;
          end else begin
            r_reg_cs <= ~w_sel;
          end
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_reg_en <= '0;
          r_reg_cs <= '1;
          r_reg_d  <= '0;
          if (!r_we && (|w_sel)) begin
            r_rdata <= bus.bus_q;
          end else begin
            r_rdata <= '0;
          end
          r_done0 <= ~r_id;
          r_done1 <= r_id;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_done0  <= 1'b0;
          r_done1  <= 1'b0;
          r_reg_en <= '0;
          r_reg_cs <= '1;
          r_reg_d  <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0   = r_gnt0;
  assign bus.gnt1   = r_gnt1;
  assign bus.done0  = r_done0;
  assign bus.done1  = r_done1;
  assign bus.rdata  = r_rdata;
  assign bus.reg_en = r_reg_en;
  assign bus.reg_cs = r_reg_cs;
  assign bus.reg_d  = r_reg_d;

endmodule
